compress_job_arbiter: RTL and testbench

- Shares one compressor datapath input (256-bit line push interface) between NUM_REQ requesters at job granularity.
- A job is a run of req_len lines from one requester. Once granted, the requester owns the datapath until its last line is pushed.
- Arbitration is round-robin.
- Credit-based flow control tracks free slots in the compressor input FIFO, so that FIFO is never overpushed.
- Sits between the DMA-side line sources and the compressor top; job_start/job_id/job_done feed the output-side bookkeeping.

---
 rtl/compress_job_arbiter_if.sv | 32 +++
 rtl/compress_job_arbiter.sv | 174 +++++++++++++++++
 tb/tb_compress_job_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/compress_job_arbiter_if.sv
// Line-push bundle between the requester-side line sources and the compressor input.
// The master modport is the source side (requesters, credit returns); slave is the arbiter.
interface compress_job_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 256,
    parameter int LEN_WIDTH  = 8,
    parameter int ID_WIDTH   = 2
);
    logic                            wrt_en;
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ*LEN_WIDTH-1:0]    req_len;
    logic [NUM_REQ*DATA_WIDTH-1:0]   req_data;
    logic [NUM_REQ-1:0]              req_ready;
    logic                            cpr_push;
    logic [DATA_WIDTH-1:0]           cpr_data;
    logic                            credit_return;
    logic                            job_start;
    logic [ID_WIDTH-1:0]             job_id;
    logic                            job_done;
    logic                            busy;
    logic                            credit_err;

    modport master (
        output wrt_en, req_valid, req_len, req_data, credit_return,
        input  req_ready, cpr_push, cpr_data, job_start, job_id, job_done, busy, credit_err
    );

    modport slave (
        input  wrt_en, req_valid, req_len, req_data, credit_return,
        output req_ready, cpr_push, cpr_data, job_start, job_id, job_done, busy, credit_err
    );
endinterface

// File: rtl/compress_job_arbiter.sv
// Round-robin, job-granular arbiter feeding one compressor input FIFO, with
// credit-based flow control so the FIFO is never overpushed.
module compress_job_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 256,
    parameter int LEN_WIDTH  = 8,
    parameter int ID_WIDTH   = 2,
    parameter int CREDITS    = 256,
    parameter int CREDIT_W   = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    compress_job_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [ID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]    gnt_q, gnt_d;
    logic [LEN_WIDTH-1:0]   remain_q, remain_d;
    logic                   first_q, first_d;
    logic [CREDIT_W-1:0]    credits_q, credits_d;

    logic                   push_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   start_q;
    logic                   done_q;
    logic [ID_WIDTH-1:0]    job_id_q;
    logic                   err_q;

    logic [ID_WIDTH-1:0]    winner;
    logic                   any_valid;
    logic [LEN_WIDTH-1:0]   win_len;
    logic [DATA_WIDTH-1:0]  gnt_data;
    logic [NUM_REQ-1:0]     ready;
    logic                   credit_ok;
    logic                   credit_full;
    logic                   credit_inc;
    logic                   xfer;
    logic                   done_fire;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        winner    = '0;
        any_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_valid && bus.req_valid[ID_WIDTH'((int'(rr_ptr_q) + i) % NUM_REQ)]) begin
                any_valid = 1'b1;
                winner    = ID_WIDTH'((int'(rr_ptr_q) + i) % NUM_REQ);
            end
        end
    end

    assign win_len  = bus.req_len[int'(winner)*LEN_WIDTH +: LEN_WIDTH];
    assign gnt_data = bus.req_data[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state and job bookkeeping; nothing advances while wrt_en is low.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        remain_d = remain_q;
        rr_ptr_d = rr_ptr_q;
        first_d  = first_q;
        if (bus.wrt_en) begin
            unique case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        gnt_d    = winner;
                        remain_d = win_len;
                        first_d  = 1'b1;
                        state_d  = (win_len == '0) ? DONE : XFER;
                    end
                end
                XFER: begin
                    if (xfer) begin
                        remain_d = remain_q - LEN_WIDTH'(1);
                        first_d  = 1'b0;
                        if (remain_q == LEN_WIDTH'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    rr_ptr_d = (gnt_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_q + ID_WIDTH'(1);
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: only the owner sees ready, and only with a free credit.
    always_comb begin
        ready     = '0;
        credit_ok = (credits_q != '0);
        if (state_q == XFER) begin
            ready[gnt_q] = bus.wrt_en & credit_ok;
        end
        xfer      = |(ready & bus.req_valid);
        done_fire = bus.wrt_en && (state_q == DONE);
    end

    // Credit counter; a return while already full is dropped and flagged.
    always_comb begin
        credit_full = (credits_q == CREDIT_W'(CREDITS));
        credit_inc  = bus.credit_return & ~credit_full;
        credits_d   = credits_q;
        unique case ({xfer, credit_inc})
            2'b10:   credits_d = credits_q - CREDIT_W'(1);
            2'b01:   credits_d = credits_q + CREDIT_W'(1);
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            remain_q  <= '0;
            first_q   <= 1'b0;
            credits_q <= CREDIT_W'(CREDITS);
            push_q    <= 1'b0;
            data_q    <= '0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            job_id_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            gnt_q     <= gnt_d;
            remain_q  <= remain_d;
            first_q   <= first_d;
            credits_q <= credits_d;
            push_q    <= xfer;
            start_q   <= xfer & first_q;
            done_q    <= done_fire;
            if (xfer) begin
                data_q <= gnt_data;
            end
            if (xfer || done_fire) begin
                job_id_q <= gnt_q;
            end
            if (bus.credit_return && credit_full) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.req_ready  = ready;
    assign bus.cpr_push   = push_q;
    assign bus.cpr_data   = data_q;
    assign bus.job_start  = start_q;
    assign bus.job_id     = job_id_q;
    assign bus.job_done   = done_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.credit_err = err_q;

endmodule

// File: tb/tb_compress_job_arbiter.sv
// Directed bench for compress_job_arbiter, built with a 4-entry credit pool so
// credit exhaustion is reachable in a few cycles.
module tb_compress_job_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 256;
    localparam int LEN_WIDTH  = 8;
    localparam int ID_WIDTH   = 2;
    localparam int CREDITS    = 4;
    localparam int CREDIT_W   = 3;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    compress_job_arbiter_if #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH), .ID_WIDTH(ID_WIDTH)
    ) bus ();

    compress_job_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH),
        .ID_WIDTH(ID_WIDTH), .CREDITS(CREDITS), .CREDIT_W(CREDIT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [DATA_WIDTH-1:0] obs,
                         input logic [DATA_WIDTH-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [DATA_WIDTH-1:0] val);
        bus.req_data[idx*DATA_WIDTH +: DATA_WIDTH] = val;
    endtask

    task automatic set_len(input int idx, input logic [LEN_WIDTH-1:0] val);
        bus.req_len[idx*LEN_WIDTH +: LEN_WIDTH] = val;
    endtask

    task automatic refill(input int n);
        bus.credit_return = 1'b1;
        repeat (n) step();
        bus.credit_return = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    function automatic logic [DATA_WIDTH-1:0] pat(input logic [31:0] w);
        return {8{w}};
    endfunction

    initial begin
        reset             = 1'b1;
        bus.wrt_en        = 1'b1;
        bus.req_valid     = '0;
        bus.req_len       = '0;
        bus.req_data      = '0;
        bus.credit_return = 1'b0;
        step();
        step();

        // Reset state
        check("rst_push",    bus.cpr_push,   0);
        check("rst_data",    bus.cpr_data,   0);
        check("rst_start",   bus.job_start,  0);
        check("rst_done",    bus.job_done,   0);
        check("rst_id",      bus.job_id,     0);
        check("rst_busy",    bus.busy,       0);
        check("rst_err",     bus.credit_err, 0);
        check("rst_credits", dut.credits_q,  CREDITS);
        reset = 1'b0;

        // Req0 alone, three lines
        set_data(0, pat(32'hD000_0000)); set_len(0, 3); bus.req_valid = 4'b0001;
        check("t1_idle_ready", bus.req_ready, 0);
        step();
        check("t1_busy", bus.busy, 1);
        check("t1_ready", bus.req_ready, 4'b0001);
        check("t1_nopush", bus.cpr_push, 0);
        step();
        check("t1_push0", bus.cpr_push, 1);
        check("t1_data0", bus.cpr_data, pat(32'hD000_0000));
        check("t1_start", bus.job_start, 1);
        check("t1_id_start", bus.job_id, 0);
        set_data(0, pat(32'hD000_0001));
        step();
        check("t1_push1", bus.cpr_push, 1);
        check("t1_data1", bus.cpr_data, pat(32'hD000_0001));
        check("t1_start_once", bus.job_start, 0);
        set_data(0, pat(32'hD000_0002));
        step();
        check("t1_push2", bus.cpr_push, 1);
        check("t1_data2", bus.cpr_data, pat(32'hD000_0002));
        check("t1_ready_done", bus.req_ready, 0);
        check("t1_no_early_done", bus.job_done, 0);
        bus.req_valid = '0;
        step();
        check("t1_push_end", bus.cpr_push, 0);
        check("t1_done", bus.job_done, 1);
        check("t1_done_id", bus.job_id, 0);
        check("t1_busy_end", bus.busy, 0);
        step();
        check("t1_done_pulse", bus.job_done, 0);
        check("t1_credits", dut.credits_q, 1);
        refill(3);
        check("t1_refill", dut.credits_q, 4);

        // Req1 and req3 contend from rr_ptr=0
        do_reset();
        check("t2_rr0", dut.rr_ptr_q, 0);
        set_data(1, pat(32'hA1A1_A1A1)); set_len(1, 2);
        set_data(3, pat(32'hA3A3_A3A3)); set_len(3, 2);
        bus.req_valid = 4'b1010;
        step();
        check("t2_ready1", bus.req_ready, 4'b0010);
        step();
        check("t2_push_a", bus.cpr_push, 1);
        check("t2_data_a", bus.cpr_data, pat(32'hA1A1_A1A1));
        check("t2_start_a", bus.job_start, 1);
        check("t2_id_a", bus.job_id, 1);
        step();
        check("t2_push_b", bus.cpr_push, 1);
        check("t2_ready_none", bus.req_ready, 0);
        step();
        check("t2_done1", bus.job_done, 1);
        check("t2_done1_id", bus.job_id, 1);
        check("t2_gap_push", bus.cpr_push, 0);
        step();
        check("t2_ready3", bus.req_ready, 4'b1000);
        check("t2_done1_pulse", bus.job_done, 0);
        step();
        check("t2_push_c", bus.cpr_push, 1);
        check("t2_data_c", bus.cpr_data, pat(32'hA3A3_A3A3));
        check("t2_start_c", bus.job_start, 1);
        check("t2_id_c", bus.job_id, 3);
        step();
        check("t2_push_d", bus.cpr_push, 1);
        step();
        check("t2_done3", bus.job_done, 1);
        check("t2_done3_id", bus.job_id, 3);
        bus.req_valid = '0;
        check("t2_rr_wrap", dut.rr_ptr_q, 0);
        check("t2_credits", dut.credits_q, 0);
        refill(4);

        // Credit exhaustion: 6 lines against 4 credits
        set_data(0, pat(32'hC0C0_C0C0)); set_len(0, 6); bus.req_valid = 4'b0001;
        step();
        check("t3_ready", bus.req_ready, 4'b0001);
        step();
        check("t3_push1", bus.cpr_push, 1);
        check("t3_start", bus.job_start, 1);
        step();
        check("t3_push2", bus.cpr_push, 1);
        step();
        check("t3_push3", bus.cpr_push, 1);
        step();
        check("t3_push4", bus.cpr_push, 1);
        check("t3_credits0", dut.credits_q, 0);
        check("t3_ready_gated", bus.req_ready, 0);
        step();
        check("t3_stall1", bus.cpr_push, 0);
        step();
        check("t3_stall2", bus.cpr_push, 0);
        check("t3_busy_stall", bus.busy, 1);
        bus.credit_return = 1'b1;
        step();
        check("t3_stall3", bus.cpr_push, 0);
        check("t3_ready_back", bus.req_ready, 4'b0001);
        step();
        check("t3_push5", bus.cpr_push, 1);
        check("t3_credit_net", dut.credits_q, 1);
        bus.credit_return = 1'b0;
        step();
        check("t3_push6", bus.cpr_push, 1);
        check("t3_ready_end", bus.req_ready, 0);
        bus.req_valid = '0;
        step();
        check("t3_done", bus.job_done, 1);
        check("t3_done_id", bus.job_id, 0);

        // Zero-length job from req2 (rr_ptr=1)
        set_len(2, 0); bus.req_valid = 4'b0100;
        step();
        check("t4_busy", bus.busy, 1);
        check("t4_ready", bus.req_ready, 0);
        check("t4_nopush", bus.cpr_push, 0);
        bus.req_valid = '0;
        step();
        check("t4_done", bus.job_done, 1);
        check("t4_done_id", bus.job_id, 2);
        check("t4_nopush2", bus.cpr_push, 0);
        check("t4_start", bus.job_start, 0);
        step();
        check("t4_idle", bus.busy, 0);
        check("t4_credits", dut.credits_q, 0);
        refill(2);

        // wrt_en stall mid-job with credit returns (credits start at 2)
        set_data(0, pat(32'hE000_0000)); set_len(0, 3); bus.req_valid = 4'b0001;
        step();
        check("t5_ready", bus.req_ready, 4'b0001);
        step();
        check("t5_push0", bus.cpr_push, 1);
        check("t5_data0", bus.cpr_data, pat(32'hE000_0000));
        check("t5_credits_a", dut.credits_q, 1);
        bus.wrt_en = 1'b0; bus.credit_return = 1'b1;
        set_data(0, pat(32'hE000_0001));
        step();
        check("t5_stall_push1", bus.cpr_push, 0);
        check("t5_stall_ready", bus.req_ready, 0);
        step();
        check("t5_stall_push2", bus.cpr_push, 0);
        step();
        check("t5_stall_push3", bus.cpr_push, 0);
        check("t5_credits_b", dut.credits_q, 4);
        check("t5_err_clear", bus.credit_err, 0);
        bus.wrt_en = 1'b1; bus.credit_return = 1'b0;
        step();
        check("t5_push1", bus.cpr_push, 1);
        check("t5_data1", bus.cpr_data, pat(32'hE000_0001));
        check("t5_nostart", bus.job_start, 0);
        set_data(0, pat(32'hE000_0002));
        step();
        check("t5_push2", bus.cpr_push, 1);
        check("t5_data2", bus.cpr_data, pat(32'hE000_0002));
        check("t5_ready_end", bus.req_ready, 0);
        bus.req_valid = '0;
        step();
        check("t5_done", bus.job_done, 1);
        check("t5_credits_c", dut.credits_q, 2);

        // Reset mid-job after 2 of 5 lines from req1
        set_data(1, pat(32'hF1F1_F1F1)); set_len(1, 5); bus.req_valid = 4'b0010;
        step();
        check("t6_ready", bus.req_ready, 4'b0010);
        step();
        check("t6_push1", bus.cpr_push, 1);
        step();
        check("t6_push2", bus.cpr_push, 1);
        reset = 1'b1;
        step();
        check("t6_push", bus.cpr_push, 0);
        check("t6_data", bus.cpr_data, 0);
        check("t6_start", bus.job_start, 0);
        check("t6_done", bus.job_done, 0);
        check("t6_id", bus.job_id, 0);
        check("t6_busy", bus.busy, 0);
        check("t6_ready_rst", bus.req_ready, 0);
        check("t6_credits", dut.credits_q, CREDITS);
        check("t6_rr", dut.rr_ptr_q, 0);
        reset = 1'b0; bus.req_valid = '0; bus.credit_return = 1'b1;
        step();
        check("t6_err_set", bus.credit_err, 1);
        check("t6_credits_cap", dut.credits_q, CREDITS);
        check("t6_no_done", bus.job_done, 0);
        bus.credit_return = 1'b0;
        step();
        step();
        check("t6_err_sticky", bus.credit_err, 1);
        check("t6_idle", bus.busy, 0);
        do_reset();
        check("t6_err_reset", bus.credit_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
